// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM states and bus constants.
// Reused by the bus-master model.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK
  } i2c_state_e;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   RW_BIT = 0;

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer plus FILT_DEPTH debounce.
// Emits the filtered level and one-cycle rise/fall pulses.
module i2c_line_filter #(
  parameter int FILT_DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lvl_q, lvl_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[0], pad_i};
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // count consecutive samples that disagree with the held level
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == 3'(FILT_DEPTH - 1)) begin
        lvl_d  = sync_q[1];
        rise_d = sync_q[1];
        fall_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C responder with 7-bit address and an 8x8 register file
// behind an auto-incrementing pointer.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILT_DEPTH = 3
) (
  input  logic       wb_clk_i,
  input  logic       rst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  input  logic [2:0] loc_adr_i,
  output logic [7:0] loc_dat_o,
  output logic       wr_stb_o,
  output logic [2:0] wr_adr_o,
  output logic       busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_DEPTH(FILT_DEPTH)) u_scl (
    .clk    (wb_clk_i),
    .rst_n  (rst_i),
    .pad_i  (scl_pad_i),
    .lvl_o  (scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILT_DEPTH(FILT_DEPTH)) u_sda (
    .clk    (wb_clk_i),
    .rst_n  (rst_i),
    .pad_i  (sda_pad_i),
    .lvl_o  (sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       nack_q, nack_d;
  logic       oen_q, oen_d;
  logic       busy_q, busy_d;
  logic       wr_stb_q, wr_stb_d;
  logic [2:0] wr_adr_q, wr_adr_d;
  logic [7:0] regs_q [8];
  logic [7:0] regs_d [8];

  logic       start_w, stop_w, rise_w, fall_w;
  logic [7:0] byte_w;

  // bus conditions outrank a coincident SCL edge
  assign start_w = sda_fall & scl_lvl;
  assign stop_w  = sda_rise & scl_lvl;
  assign rise_w  = scl_rise & ~start_w & ~stop_w;
  assign fall_w  = scl_fall & ~start_w & ~stop_w;
  assign byte_w  = {shreg_q[6:0], sda_lvl};

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    first_d  = first_q;
    nack_d   = nack_q;
    oen_d    = oen_q;
    busy_d   = busy_q;
    wr_stb_d = 1'b0;
    wr_adr_d = wr_adr_q;
    regs_d   = regs_q;
    unique case (1'b1)
      start_w: begin
        state_d = ST_ADDR;
        bit_d   = '0;
        oen_d   = 1'b1;
        busy_d  = 1'b0;
      end
      stop_w: begin
        state_d = ST_IDLE;
        oen_d   = 1'b1;
        busy_d  = 1'b0;
      end
      rise_w: begin
        case (state_q)
          ST_ADDR: begin
            if (bit_q < 4'd8) begin
              shreg_d = byte_w;
              bit_d   = bit_q + 4'd1;
              if (bit_q == 4'd7) begin
                if (byte_w[7:1] == SLAVE_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = byte_w[RW_BIT];
                end else begin
                  state_d = ST_IDLE;
                end
              end
            end
          end
          ST_WR_BYTE: begin
            if (bit_q < 4'd8) begin
              shreg_d = byte_w;
              bit_d   = bit_q + 4'd1;
              if (bit_q == 4'd7) begin
                if (first_q) begin
                  ptr_d   = byte_w[2:0];
                  first_d = 1'b0;
                end else begin
                  regs_d[ptr_q] = byte_w;
                  wr_stb_d      = 1'b1;
                  wr_adr_d      = ptr_q;
                  ptr_d         = ptr_q + 3'd1;
                end
              end
            end
          end
          ST_RD_ACK: nack_d = (sda_lvl == NACK);
          default: ;
        endcase
      end
      fall_w: begin
        case (state_q)
          ST_ADDR: begin
            if (bit_q == 4'd8) begin
              oen_d   = ACK;
              state_d = ST_ADDR_ACK;
            end
          end
          ST_ADDR_ACK: begin
            bit_d = '0;
            if (rw_q) begin
              shreg_d = regs_q[ptr_q];
              oen_d   = regs_q[ptr_q][7];
              state_d = ST_RD_BYTE;
            end else begin
              oen_d   = 1'b1;
              first_d = 1'b1;
              state_d = ST_WR_BYTE;
            end
          end
          ST_WR_BYTE: begin
            if (bit_q == 4'd8) begin
              oen_d   = ACK;
              state_d = ST_WR_ACK;
            end
          end
          ST_WR_ACK: begin
            oen_d   = 1'b1;
            bit_d   = '0;
            state_d = ST_WR_BYTE;
          end
          ST_RD_BYTE: begin
            if (bit_q == 4'd7) begin
              oen_d   = 1'b1;
              ptr_d   = ptr_q + 3'd1;
              state_d = ST_RD_ACK;
            end else begin
              shreg_d = {shreg_q[6:0], 1'b0};
              oen_d   = shreg_q[6];
              bit_d   = bit_q + 4'd1;
            end
          end
          ST_RD_ACK: begin
            if (nack_q) begin
              state_d = ST_IDLE;
            end else begin
              shreg_d = regs_q[ptr_q];
              oen_d   = regs_q[ptr_q][7];
              bit_d   = '0;
              state_d = ST_RD_BYTE;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      shreg_q  <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      first_q  <= 1'b0;
      nack_q   <= 1'b0;
      oen_q    <= 1'b1;
      busy_q   <= 1'b0;
      wr_stb_q <= 1'b0;
      wr_adr_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      ptr_q    <= ptr_d;
      rw_q     <= rw_d;
      first_q  <= first_d;
      nack_q   <= nack_d;
      oen_q    <= oen_d;
      busy_q   <= busy_d;
      wr_stb_q <= wr_stb_d;
      wr_adr_q <= wr_adr_d;
      regs_q   <= regs_d;
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = oen_q;
  assign loc_dat_o    = regs_q[loc_adr_i];
  assign wr_stb_o     = wr_stb_q;
  assign wr_adr_o     = wr_adr_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-level I2C master, register-file
// reference model and a write-strobe scoreboard.
module tb_i2c_slave_regs;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [2:0] loc_adr = '0;
  logic       sda_pad_o, sda_padoen_o;
  logic [7:0] loc_dat;
  logic       wr_stb;
  logic [2:0] wr_adr;
  logic       busy;
  logic       sda_line;

  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  always #5 clk = ~clk;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .FILT_DEPTH(3)) dut (
    .wb_clk_i     (clk),
    .rst_i        (rst_n),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_line),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .loc_adr_i    (loc_adr),
    .loc_dat_o    (loc_dat),
    .wr_stb_o     (wr_stb),
    .wr_adr_o     (wr_adr),
    .busy_o       (busy)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] mreg [8];
  logic [2:0] mptr;
  logic [2:0] exp_q [$];
  bit         oen_low_seen;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor for register write strobes
  always @(negedge clk) begin
    if (sda_padoen_o == 1'b0) oen_low_seen = 1'b1;
    if (rst_n && wr_stb) begin
      if (exp_q.size() == 0) check("unexpected_wr_stb", wr_stb, 0);
      else check("wr_adr", wr_adr, exp_q.pop_front());
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic m_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq(); wq();
  endtask

  task automatic m_bit(input logic b, output logic r);
    sda_m = b; wq();
    scl_m = 1'b1; wq();
    r = sda_line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic m_wbyte(input logic [7:0] b, output logic a);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, a);
  endtask

  task automatic m_rbyte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(nack, r);
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      loc_adr = 3'(i);
      #1;
      check(name, loc_dat, mreg[i]);
    end
  endtask

  task automatic tx_write(input logic [6:0] a, input logic [7:0] p,
                          input int n, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] d2);
    logic       l;
    logic [7:0] d [3];
    bit         match;
    d = '{d0, d1, d2};
    match = (a == 7'h50);
    m_start();
    m_wbyte({a, 1'b0}, l);
    check("addr_ack", l, match ? 0 : 1);
    if (!match) begin
      check("busy_nomatch", busy, 0);
      m_stop();
      return;
    end
    check("busy_match", busy, 1);
    m_wbyte(p, l);
    check("ptr_ack", l, 0);
    mptr = p[2:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mptr);
      mreg[mptr] = d[i];
      mptr = mptr + 3'd1;
      m_wbyte(d[i], l);
      check("data_ack", l, 0);
    end
    m_stop();
    check("busy_stop", busy, 0);
  endtask

  task automatic tx_read(input logic [6:0] a, input int n,
                         input bit set_ptr, input logic [7:0] p);
    logic       l;
    logic [7:0] d;
    bit         match;
    match = (a == 7'h50);
    m_start();
    if (set_ptr) begin
      m_wbyte({7'h50, 1'b0}, l);
      check("rd_waddr_ack", l, 0);
      m_wbyte(p, l);
      check("rd_ptr_ack", l, 0);
      mptr = p[2:0];
      m_start();
    end
    m_wbyte({a, 1'b1}, l);
    check("rd_addr_ack", l, match ? 0 : 1);
    if (match) begin
      for (int i = 0; i < n; i++) begin
        m_rbyte(i == n - 1, d);
        check("rd_data", d, mreg[mptr]);
        mptr = mptr + 3'd1;
      end
      check("busy_after_nack", busy, 1);
    end
    m_stop();
    check("busy_rd_stop", busy, 0);
  endtask

  initial begin
    logic       l, r;
    logic [6:0] a;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mptr = '0;
    repeat (4) @(negedge clk);
    check("rst_oen", sda_padoen_o, 1);
    check("rst_pad_o", sda_pad_o, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_adr", wr_adr, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_regs("rst_regs");

    tx_write(7'h50, 8'h02, 1, 8'h5A, 8'h00, 8'h00);
    check_regs("write_regs");

    tx_read(7'h50, 1, 1'b1, 8'h02);
    tx_read(7'h50, 1, 1'b0, 8'h00);

    oen_low_seen = 1'b0;
    tx_write(7'h51, 8'h03, 1, 8'hFF, 8'h00, 8'h00);
    check("mismatch_no_drive", oen_low_seen, 0);
    check_regs("mismatch_regs");

    tx_write(7'h50, 8'h07, 2, 8'h11, 8'h22, 8'h00);
    check_regs("wrap_regs");
    tx_read(7'h50, 3, 1'b1, 8'hF6);

    m_start();
    m_wbyte({7'h50, 1'b0}, l);
    m_wbyte(8'h04, l);
    mptr = 3'd4;
    for (int i = 0; i < 4; i++) m_bit(1'b1, r);
    m_stop();
    check_regs("abort_regs");
    tx_write(7'h50, 8'h04, 1, 8'hC3, 8'h00, 8'h00);
    check_regs("after_abort_regs");

    for (int t = 0; t < 12; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      if ($urandom_range(0, 1) == 0)
        tx_write(a, 8'($urandom), $urandom_range(1, 3), 8'($urandom),
                 8'($urandom), 8'($urandom));
      else
        tx_read(a, $urandom_range(1, 3), 1'($urandom), 8'($urandom));
    end
    check_regs("random_regs");

    m_start();
    for (int i = 7; i >= 0; i--) m_bit(i == 7 || i == 5, r);
    check("ack_driven", sda_padoen_o, 0);
    #3 rst_n = 1'b0;
    #1 check("async_rst_oen", sda_padoen_o, 1);
    scl_m = 1'b1;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mptr = '0;
    check_regs("async_rst_regs");
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    tx_write(7'h50, 8'h01, 2, 8'h9E, 8'h3C, 8'h00);
    tx_read(7'h50, 2, 1'b1, 8'h01);
    check_regs("final_regs");

    repeat (4) @(negedge clk);
    check("pending_wr", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
I2C responder: the other end of the bus from the existing Wishbone I2C master. It is used as a bus-model target and as an on-chip peripheral. Open-drain SDA responder with a 7-bit address and an 8x8 register file using an auto-incrementing pointer. A local read port and a write-strobe port expose the register file to system logic. It never drives SCL; there is no clock stretching.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit I2C address this block ACKs
FILT_DEPTH, 3, consecutive identical synchronized samples needed to accept a new SCL/SDA level (range 1-8)

Ports:
wb_clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-low
scl_pad_i  input  1  SCL line level
sda_pad_i  input  1  SDA line level
sda_pad_o  output  1  SDA drive value; constant 0 (open-drain)
sda_padoen_o  output  1  SDA output enable, active-low (0 = pull SDA low)
loc_adr_i  input  3  local read address
loc_dat_o  output  8  reg[loc_adr_i], combinational
wr_stb_o  output  1  one-cycle pulse when an I2C write updates a register
wr_adr_o  output  3  register index of the write; valid with wr_stb_o
busy_o  output  1  high from an address match until the next STOP or START

Behaviour:
- Reset (rst_i=0, async):
  - sda_padoen_o=1, sda_pad_o=0.
  - wr_stb_o=0, wr_adr_o=0, busy_o=0.
  - ptr=0; all 8 registers = 8'h00; FSM=IDLE.
  - Filtered SCL/SDA = 1.
- Input conditioning:
  - 2-FF synchronizer per line, then the FILT_DEPTH filter.
  - Bus timing requirement: SCL high and low phases each >= FILT_DEPTH+4 clocks.
- Events on the filtered lines, each a 1-cycle internal pulse:
  - START: SDA 1->0 while SCL=1.
  - STOP: SDA 0->1 while SCL=1.
  - rise / fall: SCL edges.
- Bit timing:
  - SDA is sampled on the SCL rise.
  - sda_padoen_o changes only on the SCL fall, 1 clock after the filtered edge.
- Bit counter: 0..8; bits 0-7 are data (MSB first), bit 8 is ACK.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
- START from any state -> ADDR, bit counter=0, sda_padoen_o=1 (covers repeated START).
- STOP from any state -> IDLE, sda_padoen_o=1, busy_o=0.
- ADDR:
  - Shift in 8 bits.
  - On the 8th rise, compare [7:1] with SLAVE_ADDR.
  - Match: busy_o=1, latch R/W, and on the next fall drive ACK (oen=0) -> ADDR_ACK.
  - Mismatch: -> IDLE; no drive until the next START.
- ADDR_ACK: on the fall ending the ACK bit:
  - Write: release -> WR_BYTE.
  - Read: load shreg=reg[ptr], drive bit 7 -> RD_BYTE.
- WR_BYTE: shift 8 bits. On the fall after bit 8, drive ACK -> WR_ACK.
  - First byte after the address is the pointer: ptr=byte[2:0], upper bits ignored, no wr_stb_o.
  - Later bytes: reg[ptr]=byte; wr_stb_o pulses 1 cycle with wr_adr_o=ptr; ptr=ptr+1 mod 8.
  - The write commits on the 8th rise.
- WR_ACK: release on the next fall -> WR_BYTE. Every addressed write byte is ACKed.
- RD_BYTE:
  - Each fall drives the next bit: oen = bit value (0 -> pull low, 1 -> release).
  - On the fall after bit 0, release -> RD_ACK, and set ptr=ptr+1 mod 8.
- RD_ACK: sample on the rise.
  - ACK (0): on the fall, load reg[ptr] and drive its bit 7 -> RD_BYTE.
  - NACK (1): -> IDLE with SDA released; busy_o stays 1 until STOP/START.
- Simultaneous events:
  - START/STOP take priority over a same-cycle rise/fall.
  - A local read in the same cycle as an I2C write returns the old value.
- Pointer wraps 7->0 on both reads and writes.
- A STOP or START mid-byte discards the partial byte; no register changes.

Decomposition:
- Shared package i2c_pkg: FSM state enum, ACK/NACK constants, and the R/W bit position. The master model reuses it.
- One sub-module, i2c_line_filter: synchronizer plus FILT_DEPTH debounce for one line. Instantiated twice (SCL, SDA); outputs the filtered level and rise/fall pulses.

Test Plan:
- Write: START, 0xA0, 0x02, 0x5A, STOP -> 3 ACKs; one wr_stb_o pulse with wr_adr_o=2; loc_adr_i=2 gives loc_dat_o=8'h5A; busy_o low after STOP.
- Combined read: START, 0xA0, 0x02, repeated START, 0xA1, master NACK, STOP -> slave drives 0x5A on SDA; ptr ends at 3.
- Address mismatch: START, 0xA2, 8 clocks, STOP -> sda_padoen_o stays 1 throughout; busy_o=0; registers unchanged.
- Pointer wrap: write ptr 0x07, then data 0x11, 0x22 -> reg7=8'h11, reg0=8'h22; wr_adr_o sequence 7, 0.
- Abort: STOP after 4 bits of a data byte -> IDLE; no wr_stb_o; the target register keeps its old value. Next full transaction succeeds.
- Async reset while driving ACK -> sda_padoen_o=1 in the same cycle without a clock edge; all registers read 8'h00.
